// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two zero-latency read ports and a sequenced bulk clear.
// Optional write-through forwarding to both read ports when REGFILE_BYPASS_EN is defined.
module reg_file_param #(
    parameter int WIDTH     = 16,
    parameter int NUM_REGS  = 16,
    parameter int ZERO_REG0 = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_en1,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    input  logic             rd_en2,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             clr_req,
    output logic             busy
);

    localparam logic [AW:0]   NUM_REGS_W = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e           state_r;
    logic [AW-1:0]    cnt_r;
    logic             busy_r;
    logic             wr_ready_r;
    logic [WIDTH-1:0] mem_r [NUM_REGS];
    logic             wr_fire_s;
    logic [WIDTH-1:0] rd_data1_s;
    logic [WIDTH-1:0] rd_data2_s;

    // A word is live when it exists and is not the hard-wired zero register.
    function automatic logic addr_live(input logic [AW-1:0] addr);
        logic ok;
        ok = ({1'b0, addr} < NUM_REGS_W);
        if ((ZERO_REG0 != 0) && (addr == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    assign wr_fire_s = wr_en & wr_ready_r & addr_live(wr_addr);

    // Clear sequencer: walks cnt over every word; busy and wr_ready are decoded into flops here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            busy_r     <= 1'b0;
            wr_ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (clr_req) begin
                        state_r    <= ST_CLEAR;
                        busy_r     <= 1'b1;
                        wr_ready_r <= 1'b0;
                    end else begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        wr_ready_r <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_r == LAST_IDX) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= '0;
                        busy_r     <= 1'b0;
                        wr_ready_r <= 1'b1;
                    end else begin
                        state_r    <= ST_CLEAR;
                        cnt_r      <= cnt_r + AW'(1);
                        busy_r     <= 1'b1;
                        wr_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= '0;
                    busy_r     <= 1'b0;
                    wr_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Storage: reset wipes everything, the clear engine owns the array while busy, otherwise writeback.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (state_r == ST_CLEAR) begin
            mem_r[cnt_r] <= '0;
        end else if (wr_fire_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port 1 mux; disabled or dead addresses return zero.
    always_comb begin
        rd_data1_s = '0;
        if (rd_en1 && addr_live(rd_addr1)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_fire_s && (rd_addr1 == wr_addr)) begin
                rd_data1_s = wr_data;
            end else begin
                rd_data1_s = mem_r[rd_addr1];
            end
`else
            rd_data1_s = mem_r[rd_addr1];
`endif
        end else begin
            rd_data1_s = '0;
        end
    end

    // Read port 2 mux, identical to port 1 and independent of it.
    always_comb begin
        rd_data2_s = '0;
        if (rd_en2 && addr_live(rd_addr2)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_fire_s && (rd_addr2 == wr_addr)) begin
                rd_data2_s = wr_data;
            end else begin
                rd_data2_s = mem_r[rd_addr2];
            end
`else
            rd_data2_s = mem_r[rd_addr2];
`endif
        end else begin
            rd_data2_s = '0;
        end
    end

    assign rd_data1 = rd_data1_s;
    assign rd_data2 = rd_data2_s;
    assign busy     = busy_r;
    assign wr_ready = wr_ready_r;

endmodule
